keypad_entry: RTL and testbench
===============================

# keypad_entry

Collects keypad presses from the keypad synchronizer/encoder (5-bit key code plus synchronized press strobe) and assembles them into a hexadecimal operand for the RV32I test harness. Each press is acted on exactly once. Hex keys shift digits in, and control keys backspace, clear or commit the entry. A committed value is presented with a one-cycle valid pulse to the downstream consumer, such as the register/memory poke logic.

## Interface
Parameters:
- MAX_DIGITS, 8, maximum number of hex digits held (legal 1..8)

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clock
- key_code  input  5  encoded key index from synchronizer (0..19)
- key_strobe  input  1  synchronized "a key is held" level from synchronizer
- entry  output  32  live value being typed, right-aligned, unused upper nibbles zero
- digit_count  output  4  digits currently in entry (0..MAX_DIGITS)
- full  output  1  digit_count == MAX_DIGITS (combinational from digit_count)
- result  output  32  last committed value
- result_valid  output  1  one-cycle pulse when result is updated
- key_error  output  1  one-cycle pulse on a rejected key

## Operation
- Key map: codes 0–15 are hex digits 0x0–0xF. 16 is BACKSPACE, 17 is CLEAR, 18 is ENTER. 19 is reserved and ignored (no error).
- Press FSM, 2 states:
  - WAIT_PRESS: on key_strobe=1, act on key_code sampled that cycle and go to WAIT_RELEASE.
  - WAIT_RELEASE: ignore all input until key_strobe=0, then go to WAIT_PRESS.
  - Each press (strobe high interval) produces exactly one action regardless of duration.
- Digit, not full: entry <= (entry << 4) | code[3:0], masked to 4*MAX_DIGITS bits; digit_count++.
- Digit, full: entry and digit_count unchanged; key_error pulses.
- BACKSPACE, digit_count>0: entry <= entry >> 4; digit_count--.
- BACKSPACE, digit_count==0: no change; key_error pulses.
- CLEAR: entry <= 0, digit_count <= 0. No error even if already empty.
- ENTER, digit_count>0: result <= entry; result_valid pulses; entry <= 0; digit_count <= 0.
- ENTER, digit_count==0: no change to result, no result_valid; key_error pulses.
- result holds its value until the next successful ENTER or reset.

## Timing
- Reset values: state=WAIT_RELEASE, entry=0, digit_count=0, full=0, result=0, result_valid=0, key_error=0.
- Reset to WAIT_RELEASE is deliberate: a key held through reset is not accepted. The FSM first requires one cycle with key_strobe=0.
- Reset asserted mid-press or on the same edge as an accepted press wins. No action is taken and all registers take reset values.
- Latency: if key_strobe=1 in WAIT_PRESS at edge N, the updates to entry, digit_count, result, result_valid and key_error are visible after edge N.
- result_valid and key_error are high for exactly the cycle after edge N and return to 0 at edge N+1. They are never both high.
- Minimum press-to-press spacing: strobe low for at least 1 cycle. A strobe that drops for one cycle and rises again counts as a new press.
- key_code is sampled only on the accepting edge. Changes to key_code during WAIT_RELEASE have no effect.
- full changes in the same cycle as digit_count.

## Test plan
- Reset, then one cycle strobe low, then press 0x1, 0x2, 0xA as separate 3-cycle strobe pulses, then ENTER:
  - entry goes 0x1, 0x12, 0x12A, then 0.
  - result=0x0000012A with result_valid high exactly 1 cycle; digit_count ends at 0.
- Hold key 0x5 strobe high for 20 cycles -> entry=0x5, digit_count=1; single acceptance only.
- With MAX_DIGITS=8, press 9 digits 1..9 -> entry=0x12345678, full=1; 9th press gives key_error pulse with entry unchanged.
- Type 0x3, 0x4, then BACKSPACE twice, then BACKSPACE again:
  - entry goes 0x34, 0x3, 0.
  - The third BACKSPACE pulses key_error.
  - ENTER on empty entry pulses key_error with result unchanged.
- Hold key_strobe high while asserting reset for 2 cycles, release reset with strobe still high for 5 more cycles -> no action taken; next genuine press after strobe low is accepted.
- Press key 19, then CLEAR on empty entry -> no key_error, no result_valid, all outputs unchanged.

Source files
------------

// File: rtl/keypad_entry.sv
// Keypad hex operand entry: one action per key press, shifting digits into a
// live entry and committing it to result with a single-cycle valid pulse.
module keypad_entry #(
    parameter int MAX_DIGITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  key_code,
    input  logic        key_strobe,
    output logic [31:0] entry,
    output logic [3:0]  digit_count,
    output logic        full,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        key_error,
    output logic        press_state
);

    typedef enum logic {
        WAIT_PRESS   = 1'b0,
        WAIT_RELEASE = 1'b1
    } press_state_e;

    localparam logic [31:0] ENTRY_MASK = (32'd1 << (4 * MAX_DIGITS)) - 32'd1;
    localparam logic [3:0]  MAX_COUNT  = 4'(MAX_DIGITS);

    localparam logic [4:0] KEY_BACKSPACE = 5'd16;
    localparam logic [4:0] KEY_CLEAR     = 5'd17;
    localparam logic [4:0] KEY_ENTER     = 5'd18;

    press_state_e state_q, state_d;
    logic [31:0]  entry_q, entry_d;
    logic [3:0]   count_q, count_d;
    logic [31:0]  result_q, result_d;
    logic         valid_q, valid_d;
    logic         error_q, error_d;
    logic         full_w;

    assign full_w = (count_q == MAX_COUNT);

    always_ff @(posedge clock) begin
        if (reset) begin
            // Starting in WAIT_RELEASE rejects a key still held through reset.
            state_q  <= WAIT_RELEASE;
            entry_q  <= 32'd0;
            count_q  <= 4'd0;
            result_q <= 32'd0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            count_q  <= count_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        count_d  = count_q;
        result_d = result_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        case (state_q)
            WAIT_PRESS: begin
                if (key_strobe) begin
                    state_d = WAIT_RELEASE;
                    if (key_code <= 5'd15) begin
                        if (full_w) begin
                            error_d = 1'b1;
                        end else begin
                            entry_d = ((entry_q << 4) | {28'd0, key_code[3:0]}) & ENTRY_MASK;
                            count_d = count_q + 4'd1;
                        end
                    end else if (key_code == KEY_BACKSPACE) begin
                        if (count_q == 4'd0) begin
                            error_d = 1'b1;
                        end else begin
                            entry_d = entry_q >> 4;
                            count_d = count_q - 4'd1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        entry_d = 32'd0;
                        count_d = 4'd0;
                    end else if (key_code == KEY_ENTER) begin
                        if (count_q == 4'd0) begin
                            error_d = 1'b1;
                        end else begin
                            result_d = entry_q;
                            valid_d  = 1'b1;
                            entry_d  = 32'd0;
                            count_d  = 4'd0;
                        end
                    end
                    // Code 19 and above: accepted as a press but no action.
                end
            end
            WAIT_RELEASE: begin
                if (!key_strobe) begin
                    state_d = WAIT_PRESS;
                end
            end
            default: state_d = WAIT_RELEASE;
        endcase
    end

    assign entry        = entry_q;
    assign digit_count  = count_q;
    assign full         = full_w;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign key_error    = error_q;
    assign press_state  = state_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: a reference model pushes the expected
// post-press outputs to a queue, popped and compared one cycle after acceptance.
module tb_keypad_entry;

    localparam int MAXD = 8;
    localparam int W    = 71;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  key_code;
    logic        key_strobe;
    logic [31:0] entry;
    logic [3:0]  digit_count;
    logic        full;
    logic [31:0] result;
    logic        result_valid;
    logic        key_error;
    logic        press_state;

    keypad_entry #(.MAX_DIGITS(MAXD)) dut (
        .clock        (clock),
        .reset        (reset),
        .key_code     (key_code),
        .key_strobe   (key_strobe),
        .entry        (entry),
        .digit_count  (digit_count),
        .full         (full),
        .result       (result),
        .result_valid (result_valid),
        .key_error    (key_error),
        .press_state  (press_state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    logic [31:0] m_entry;
    int          m_count;
    logic [31:0] m_result;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] digit_mask();
        logic [63:0] m;
        m = (64'd1 << (4 * MAXD)) - 64'd1;
        return m[31:0];
    endfunction

    // Reference behaviour of one accepted press; pushes the expected outputs.
    task automatic model_press(input logic [4:0] code);
        logic v, e;
        v = 1'b0;
        e = 1'b0;
        if (code <= 5'd15) begin
            if (m_count == MAXD) e = 1'b1;
            else begin
                m_entry = ((m_entry << 4) | {28'd0, code[3:0]}) & digit_mask();
                m_count++;
            end
        end else if (code == 5'd16) begin
            if (m_count == 0) e = 1'b1;
            else begin
                m_entry = m_entry >> 4;
                m_count--;
            end
        end else if (code == 5'd17) begin
            m_entry = 32'd0;
            m_count = 0;
        end else if (code == 5'd18) begin
            if (m_count == 0) e = 1'b1;
            else begin
                m_result = m_entry;
                v = 1'b1;
                m_entry = 32'd0;
                m_count = 0;
            end
        end
        exp_q.push_back({m_entry, 4'(m_count), (m_count == MAXD), m_result, v, e});
    endtask

    task automatic check_popped(input string tag);
        logic [W-1:0] x;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
            return;
        end
        x = exp_q.pop_front();
        check_eq({tag, "_entry"},  entry,                x[70:39]);
        check_eq({tag, "_count"},  {28'd0, digit_count}, {28'd0, x[38:35]});
        check_eq({tag, "_full"},   {31'd0, full},        {31'd0, x[34]});
        check_eq({tag, "_result"}, result,               x[33:2]);
        check_eq({tag, "_valid"},  {31'd0, result_valid}, {31'd0, x[1]});
        check_eq({tag, "_error"},  {31'd0, key_error},   {31'd0, x[0]});
    endtask

    // Steady-state check: no pulses, entry/count/result match the model.
    task automatic check_idle(input string tag);
        check_eq({tag, "_idle_entry"},  entry,                m_entry);
        check_eq({tag, "_idle_count"},  {28'd0, digit_count}, 32'(m_count));
        check_eq({tag, "_idle_result"}, result,               m_result);
        check_eq({tag, "_idle_pulses"}, {30'd0, result_valid, key_error}, 32'd0);
    endtask

    // One press: strobe high for hold cycles then low for one cycle.
    task automatic press(input logic [4:0] code, input int hold, input string tag);
        key_code   = code;
        key_strobe = 1'b1;
        @(posedge clock);
        model_press(code);
        #1;
        check_popped(tag);
        for (int i = 1; i < hold; i++) begin
            key_code = 5'($urandom_range(0, 19));
            @(posedge clock);
            #1;
            check_idle({tag, "_hold"});
        end
        key_strobe = 1'b0;
        key_code   = 5'($urandom_range(0, 19));
        @(posedge clock);
        #1;
        check_idle({tag, "_rel"});
    endtask

    task automatic model_reset();
        m_entry  = 32'd0;
        m_count  = 0;
        m_result = 32'd0;
        exp_q.delete();
    endtask

    initial begin
        reset      = 1'b1;
        key_strobe = 1'b0;
        key_code   = 5'd0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_eq("reset_entry",  entry, 32'd0);
        check_eq("reset_count",  {28'd0, digit_count}, 32'd0);
        check_eq("reset_full",   {31'd0, full}, 32'd0);
        check_eq("reset_result", result, 32'd0);
        check_eq("reset_pulses", {30'd0, result_valid, key_error}, 32'd0);
        check_eq("reset_state",  {31'd0, press_state}, 32'd1);
        @(posedge clock);
        #1;

        // Basic entry and commit
        press(5'h1, 3, "d1");
        press(5'h2, 3, "d2");
        press(5'hA, 3, "dA");
        press(5'd18, 3, "enter");

        // Long hold is a single acceptance
        press(5'h5, 20, "hold5");
        press(5'd17, 2, "clr1");

        // Fill to capacity, then overflow
        for (int d = 1; d <= 9; d++) press(5'(d), 2, $sformatf("fill%0d", d));
        check_eq("full_entry", entry, 32'h12345678);
        check_eq("full_flag",  {31'd0, full}, 32'd1);
        press(5'd16, 1, "bs_full");
        check_eq("bs_full_flag", {31'd0, full}, 32'd0);
        press(5'd17, 1, "clr2");

        // Backspace to empty, underflow and empty-enter errors
        press(5'h3, 2, "d3");
        press(5'h4, 2, "d4");
        press(5'd16, 2, "bs1");
        press(5'd16, 2, "bs2");
        press(5'd16, 2, "bs3");
        press(5'd18, 2, "enter_empty");

        // Reserved key and clear on empty entry
        press(5'd19, 2, "rsv");
        press(5'd17, 2, "clr_empty");

        // Random presses against the model
        for (int i = 0; i < 40; i++)
            press(5'($urandom_range(0, 19)), $urandom_range(1, 4), $sformatf("rnd%0d", i));

        // Reset while a key is held
        press(5'hB, 1, "preB");
        key_code   = 5'h6;
        key_strobe = 1'b1;
        reset      = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        check_idle("rst_held");
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check_idle("rst_still_held");
        end
        key_strobe = 1'b0;
        @(posedge clock);
        #1;
        press(5'h7, 2, "after_rst");
        check_eq("after_rst_entry", entry, 32'h7);
        press(5'd18, 2, "after_rst_enter");

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
